qualified_event_counter: RTL and testbench

Parametrised event counter. It combines an N-bit qualifier vector into one qualified event. The reduction mode is selectable: AND, OR, parity or majority. It counts these events up or down against a programmable limit, with wrap or saturate behaviour. It sits next to the control logic as the generalised successor of the fixed 3-input/5-bit counter, adding load, direction, limit, terminal-count and overflow reporting.

---
 rtl/qec_pkg.sv | 24 ++
 rtl/qec_if.sv | 31 +++
 rtl/qec_qualifier.sv | 37 +++
 rtl/qualified_event_counter.sv | 116 +++++++++++
 tb/tb_qualified_event_counter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/qec_pkg.sv
// Shared encodings for the qualified event counter: reduction modes,
// counter FSM states and the bound/edge behaviour selectors.
package qec_pkg;

  // Reduction applied to the qualifier vector
  localparam logic [1:0] QEC_AND = 2'b00;
  localparam logic [1:0] QEC_OR  = 2'b01;
  localparam logic [1:0] QEC_XOR = 2'b10;
  localparam logic [1:0] QEC_MAJ = 2'b11;

  // Counter FSM: free counting, or parked on a bound in saturate mode
  typedef logic [0:0] qec_state_t;
  localparam qec_state_t RUN  = 1'b0;
  localparam qec_state_t HELD = 1'b1;

  // Bound behaviour
  localparam int SAT_WRAP = 0;
  localparam int SAT_HOLD = 1;

  // Qualifier sensitivity
  localparam int EDGE_LEVEL = 0;
  localparam int EDGE_RISE  = 1;

endpackage

// File: rtl/qec_if.sv
// Control/status bundle between the surrounding control logic (master)
// and the qualified event counter (slave).
interface qec_if #(
  parameter int WIDTH = 5,
  parameter int N_IN  = 3
) ();

  logic             en;
  logic [N_IN-1:0]  in_vec;
  logic [1:0]       sel_mode;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] counter;
  logic             d;
  logic             tc;
  logic             sat;
  logic             ovf;

  modport master (
    output en, in_vec, sel_mode, up_dn, load, load_val, limit,
    input  counter, d, tc, sat, ovf
  );

  modport slave (
    input  en, in_vec, sel_mode, up_dn, load, load_val, limit,
    output counter, d, tc, sat, ovf
  );

endinterface

// File: rtl/qec_qualifier.sv
// Combinational reduction of the qualifier vector to a single qualified
// event bit: AND, OR, odd parity or strict majority.
module qec_qualifier
  import qec_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic [N_IN-1:0] in_vec,
  input  logic [1:0]      sel_mode,
  output logic            qual
);

  localparam int CW = $clog2(N_IN + 1);

  logic [CW-1:0] ones;

  // Population count feeding the majority vote
  always_comb begin
    ones = '0;
    for (int i = 0; i < N_IN; i++) begin
      ones = ones + CW'(in_vec[i]);
    end
  end

  // Mode select; majority needs strictly more than half the inputs set
  always_comb begin
    qual = 1'b0;
    case (sel_mode)
      QEC_AND: qual = &in_vec;
      QEC_OR:  qual = |in_vec;
      QEC_XOR: qual = ^in_vec;
      QEC_MAJ: qual = (ones > CW'(N_IN / 2));
      default: qual = 1'b0;
    endcase
  end

endmodule

// File: rtl/qualified_event_counter.sv
// Up/down event counter against a programmable inclusive limit, with
// wrap or saturate at the bounds, sticky overflow and a terminal-count
// pulse. Events come from a reduced qualifier vector, level or edge.
module qualified_event_counter
  import qec_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int N_IN      = 3,
  parameter int SAT_MODE  = SAT_WRAP,
  parameter int EDGE_MODE = EDGE_LEVEL
) (
  input logic clk,
  input logic rst,
  qec_if.slave bus
);

  logic             qual;
  logic             qual_q;
  logic             d_q;
  logic             evt;
  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_nxt;
  qec_state_t       state_q;
  qec_state_t       state_nxt;
  logic             tc_q;
  logic             tc_nxt;
  logic             ovf_q;
  logic             ovf_nxt;

  qec_qualifier #(.N_IN(N_IN)) u_qualifier (
    .in_vec   (bus.in_vec),
    .sel_mode (bus.sel_mode),
    .qual     (qual)
  );

  // A counter above a lowered limit is treated as sitting on the limit
  assign at_top = (count_q >= bus.limit);
  assign at_bot = (count_q == '0);

  // Qualified event: level, or rising edge against last cycle's qualifier
  always_comb begin
    if (EDGE_MODE == EDGE_RISE) evt = bus.en & qual & ~qual_q;
    else                        evt = bus.en & qual;
  end

  // Next count/state/flags: load beats event beats hold
  always_comb begin
    count_nxt = count_q;
    state_nxt = state_q;
    tc_nxt    = 1'b0;
    ovf_nxt   = ovf_q;
    if (bus.load) begin
      count_nxt = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
      state_nxt = RUN;
      ovf_nxt   = 1'b0;
    end else if (evt) begin
      if (bus.up_dn) begin
        if (at_top) begin
          ovf_nxt = 1'b1;
          if (SAT_MODE == SAT_HOLD) begin
            state_nxt = HELD;
            tc_nxt    = (state_q == RUN);
          end else begin
            count_nxt = '0;
            tc_nxt    = 1'b1;
          end
        end else begin
          count_nxt = count_q + WIDTH'(1);
          state_nxt = RUN;
        end
      end else begin
        if (at_bot) begin
          ovf_nxt = 1'b1;
          if (SAT_MODE == SAT_HOLD) begin
            state_nxt = HELD;
            tc_nxt    = (state_q == RUN);
          end else begin
            count_nxt = bus.limit;
            tc_nxt    = 1'b1;
          end
        end else begin
          count_nxt = count_q - WIDTH'(1);
          state_nxt = RUN;
        end
      end
    end
  end

  // State registers; the qualifier pipeline runs regardless of en
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      state_q <= RUN;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      qual_q  <= 1'b0;
      d_q     <= 1'b0;
    end else begin
      count_q <= count_nxt;
      state_q <= state_nxt;
      tc_q    <= tc_nxt;
      ovf_q   <= ovf_nxt;
      qual_q  <= qual;
      d_q     <= qual;
    end
  end

  assign bus.counter = count_q;
  assign bus.d       = d_q;
  assign bus.tc      = tc_q;
  assign bus.sat     = (state_q == HELD);
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_qualified_event_counter.sv
// Bench for qualified_event_counter: four instances covering wrap/saturate
// and level/edge sharing one stimulus, checked each cycle against a
// behavioural model plus directed expectations.
module tb_qualified_event_counter;

  localparam int W  = 5;
  localparam int NI = 3;

  logic          clk;
  logic          rst;
  logic          en;
  logic [NI-1:0] in_vec;
  logic [1:0]    sel_mode;
  logic          up_dn;
  logic          load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  limit;

  logic [W-1:0]  cnt_o [4];
  logic          d_o   [4];
  logic          tc_o  [4];
  logic          sat_o [4];
  logic          ovf_o [4];

  int errors = 0;
  int checks = 0;

  // Model state per instance: c = {EDGE_MODE, SAT_MODE}
  int m_cnt  [4];
  bit m_held [4];
  bit m_ovf  [4];
  bit m_tc   [4];
  bit m_d    [4];
  bit m_qq   [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    qec_if #(.WIDTH(W), .N_IN(NI)) bus ();
    assign bus.en       = en;
    assign bus.in_vec   = in_vec;
    assign bus.sel_mode = sel_mode;
    assign bus.up_dn    = up_dn;
    assign bus.load     = load;
    assign bus.load_val = load_val;
    assign bus.limit    = limit;
    assign cnt_o[g]     = bus.counter;
    assign d_o[g]       = bus.d;
    assign tc_o[g]      = bus.tc;
    assign sat_o[g]     = bus.sat;
    assign ovf_o[g]     = bus.ovf;
    qualified_event_counter #(
      .WIDTH(W), .N_IN(NI), .SAT_MODE(g % 2), .EDGE_MODE(g / 2)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  function automatic bit ref_qual(input logic [NI-1:0] v, input logic [1:0] m);
    int n;
    n = $countones(v);
    case (m)
      2'd0:    return n == NI;
      2'd1:    return n > 0;
      2'd2:    return (n % 2) == 1;
      default: return n > NI / 2;
    endcase
  endfunction

  task automatic model_step(input int c);
    bit q;
    bit ev;
    bit is_sat;
    bit is_edge;
    is_sat  = (c % 2) == 1;
    is_edge = (c / 2) == 1;
    if (!rst) begin
      m_cnt[c] = 0; m_held[c] = 0; m_ovf[c] = 0;
      m_tc[c] = 0; m_d[c] = 0; m_qq[c] = 0;
    end else begin
      q  = ref_qual(in_vec, sel_mode);
      ev = en && q && (!is_edge || !m_qq[c]);
      m_tc[c] = 0;
      if (load) begin
        m_cnt[c]  = (int'(load_val) < int'(limit)) ? int'(load_val) : int'(limit);
        m_ovf[c]  = 0;
        m_held[c] = 0;
      end else if (ev && up_dn) begin
        if (m_cnt[c] >= int'(limit)) begin
          m_ovf[c] = 1;
          if (is_sat) begin m_tc[c] = !m_held[c]; m_held[c] = 1; end
          else begin m_cnt[c] = 0; m_tc[c] = 1; end
        end else begin
          m_cnt[c]++; m_held[c] = 0;
        end
      end else if (ev) begin
        if (m_cnt[c] == 0) begin
          m_ovf[c] = 1;
          if (is_sat) begin m_tc[c] = !m_held[c]; m_held[c] = 1; end
          else begin m_cnt[c] = int'(limit); m_tc[c] = 1; end
        end else begin
          m_cnt[c]--; m_held[c] = 0;
        end
      end
      m_d[c]  = q;
      m_qq[c] = q;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model on the driven inputs, then compare all
  task automatic tick();
    for (int c = 0; c < 4; c++) model_step(c);
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("cnt[%0d]", c), 32'(cnt_o[c]), 32'(m_cnt[c]));
      chk($sformatf("d[%0d]", c),   32'(d_o[c]),   32'(m_d[c]));
      chk($sformatf("tc[%0d]", c),  32'(tc_o[c]),  32'(m_tc[c]));
      chk($sformatf("sat[%0d]", c), 32'(sat_o[c]), 32'(m_held[c]));
      chk($sformatf("ovf[%0d]", c), 32'(ovf_o[c]), 32'(m_ovf[c]));
    end
  endtask

  initial begin
    int exp_seq [6];
    exp_seq = '{1, 2, 3, 4, 5, 0};

    // Reset held two edges against load and a true qualifier
    rst = 1'b0; en = 1'b1; in_vec = 3'b111; sel_mode = 2'b00;
    up_dn = 1'b1; load = 1'b1; load_val = 5'd7; limit = 5'd5;
    tick(); tick();
    chk("rst_cnt", 32'(cnt_o[0]), 32'd0);
    chk("rst_d",   32'(d_o[0]),   32'd0);
    chk("rst_ovf", 32'(ovf_o[1]), 32'd0);

    // Wrap/saturate going up through limit=5, AND mode
    rst = 1'b1; load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("wrap_seq", 32'(cnt_o[0]), 32'(exp_seq[i]));
    end
    chk("wrap_tc",  32'(tc_o[0]),  32'd1);
    chk("wrap_ovf", 32'(ovf_o[0]), 32'd1);
    chk("sat_hold", 32'(cnt_o[1]), 32'd5);
    chk("sat_tc",   32'(tc_o[1]),  32'd1);
    chk("sat_lvl",  32'(sat_o[1]), 32'd1);
    tick();
    chk("wrap_tc_low", 32'(tc_o[0]),  32'd0);
    chk("sat_tc_once", 32'(tc_o[1]),  32'd0);
    chk("edge_once",   32'(cnt_o[2]), 32'd1);
    up_dn = 1'b0;
    tick();
    chk("sat_leave_cnt", 32'(cnt_o[1]), 32'd4);
    chk("sat_leave_sat", 32'(sat_o[1]), 32'd0);
    chk("wrap_ovf_sticky", 32'(ovf_o[0]), 32'd1);

    // Majority mode
    up_dn = 1'b1; load = 1'b1; load_val = 5'd0;
    tick();
    load = 1'b0; sel_mode = 2'b11; in_vec = 3'b110;
    tick();
    chk("maj_cnt", 32'(cnt_o[0]), 32'd1);
    chk("maj_d",   32'(d_o[0]),   32'd1);
    in_vec = 3'b100;
    tick();
    chk("maj_nocnt", 32'(cnt_o[0]), 32'd1);
    chk("maj_d0",    32'(d_o[0]),   32'd0);

    // Load clamps to limit and beats a simultaneous event
    limit = 5'd10; load_val = 5'd20; load = 1'b1;
    tick();
    chk("load_clamp", 32'(cnt_o[0]), 32'd10);
    chk("load_ovf",   32'(ovf_o[0]), 32'd0);
    load_val = 5'd3; sel_mode = 2'b00; in_vec = 3'b111;
    tick();
    chk("load_vs_evt", 32'(cnt_o[0]), 32'd3);
    load = 1'b0;
    tick();
    chk("after_load", 32'(cnt_o[0]), 32'd4);

    // Down wrap from zero
    limit = 5'd7; load = 1'b1; load_val = 5'd0;
    tick();
    load = 1'b0; up_dn = 1'b0;
    tick();
    chk("dn_wrap_cnt", 32'(cnt_o[0]), 32'd7);
    chk("dn_wrap_tc",  32'(tc_o[0]),  32'd1);
    chk("dn_sat_cnt",  32'(cnt_o[1]), 32'd0);

    // Reset mid-count overrides load
    load = 1'b1; load_val = 5'd3;
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst", 32'(cnt_o[0]), 32'd0);
    rst = 1'b1; load = 1'b0; en = 1'b0;
    tick();

    // limit=0: every up event is a bound event
    limit = 5'd0; en = 1'b1; up_dn = 1'b1;
    tick();
    chk("lim0_tc_a", 32'(tc_o[0]), 32'd1);
    tick();
    chk("lim0_tc_b", 32'(tc_o[0]), 32'd1);
    chk("lim0_cnt",  32'(cnt_o[0]), 32'd0);

    // Limit lowered below the count
    limit = 5'd15; load = 1'b1; load_val = 5'd9;
    tick();
    load = 1'b0; limit = 5'd4;
    tick();
    chk("low_lim_wrap", 32'(cnt_o[0]), 32'd0);
    chk("low_lim_sat",  32'(cnt_o[1]), 32'd9);
    chk("low_lim_satf", 32'(sat_o[1]), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(63) != 0);
      en       = ($urandom_range(3) != 0);
      in_vec   = NI'($urandom);
      sel_mode = 2'($urandom);
      up_dn    = ($urandom_range(9) < 6);
      load     = ($urandom_range(15) == 0);
      load_val = W'($urandom);
      if ($urandom_range(31) == 0) limit = W'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
